// File: rtl/voice_sched_pkg.sv
// Shared types and helpers for the voice scheduler.
// Consumed by voice_scheduler, voice_slot_pick and voice_scheduler_if.
package voice_sched_pkg;
  localparam int NOTE_W       = 4;
  localparam int AGE_W        = 4;
  localparam int NUM_VOICES_C = 4;

  typedef logic [NOTE_W-1:0] note_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT,
    WAIT_RDY
  } state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/voice_scheduler_if.sv
// Keypad/datapath-facing bundle of the voice scheduler.
// master = keypad/combiner side, slave = scheduler.
interface voice_scheduler_if #(
  parameter int NUM_KEYS = 13
);
  import voice_sched_pkg::*;

  logic [NUM_KEYS-1:0]            keys;
  logic                           sample_tick;
  logic                           comb_ready;
  logic [NOTE_W*NUM_VOICES_C-1:0] voice_note;
  logic [NUM_VOICES_C-1:0]        voice_valid;
  logic [2:0]                     num_signals;
  logic                           sample_go;
  logic                           overrun;
  logic                           busy;

  modport master (
    output keys, sample_tick, comb_ready,
    input  voice_note, voice_valid, num_signals,
    input  sample_go, overrun, busy
  );

  modport slave (
    input  keys, sample_tick, comb_ready,
    output voice_note, voice_valid, num_signals,
    output sample_go, overrun, busy
  );
endinterface

// File: rtl/voice_scheduler_slot_pick.sv
// Combinational slot selector: lowest free slot, or (VOICE_SCHED_STEAL_EN)
// the oldest valid slot when none is free.
module voice_slot_pick
  import voice_sched_pkg::*;
(
  input  logic [NUM_VOICES_C-1:0]       valid_i,
  input  logic [AGE_W*NUM_VOICES_C-1:0] ages_i,
  input  logic [NUM_VOICES_C-1:0]       match_i,
  output logic [NUM_VOICES_C-1:0]       pick_o,
  output logic                          found_o
);
  localparam int SEL_W = $clog2(NUM_VOICES_C);

  logic [NUM_VOICES_C-1:0] free_oh;

  always_comb begin
    free_oh = '0;
    for (int v = NUM_VOICES_C-1; v >= 0; v--) begin
      if (!valid_i[v]) begin
        free_oh    = '0;
        free_oh[v] = 1'b1;
      end
    end
  end

`ifdef VOICE_SCHED_STEAL_EN
  logic [AGE_W-1:0]        age [NUM_VOICES_C];
  logic [SEL_W-1:0]        best;
  logic [NUM_VOICES_C-1:0] old_oh;

  always_comb begin
    for (int v = 0; v < NUM_VOICES_C; v++)
      age[v] = ages_i[v*AGE_W +: AGE_W];
  end

  // Scan downward with >= so ties resolve to the lowest slot
  always_comb begin
    best = SEL_W'(NUM_VOICES_C-1);
    for (int v = NUM_VOICES_C-2; v >= 0; v--) begin
      if (age[v] >= age[best])
        best = SEL_W'(v);
    end
    old_oh       = '0;
    old_oh[best] = 1'b1;
  end

  assign pick_o  = (|free_oh) ? free_oh : old_oh;
  assign found_o = ~|match_i;
`else
  logic unused_ages;
  assign unused_ages = ^ages_i;

  assign pick_o  = free_oh;
  assign found_o = ~|match_i & |free_oh;
`endif
endmodule

// File: rtl/voice_scheduler.sv
// Key-to-voice allocator and per-tick sample sequencer.
// Optional voice stealing by age: define VOICE_SCHED_STEAL_EN.
module voice_scheduler
  import voice_sched_pkg::*;
#(
  parameter int NUM_KEYS    = 13,
  parameter int NUM_VOICES  = 4,
  parameter int RDY_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             n_rst,
  voice_scheduler_if.slave bus
);
  localparam int    NW    = NOTE_W*NUM_VOICES;
  localparam int    AW    = AGE_W*NUM_VOICES;
  localparam int    CNT_W = $clog2(RDY_TIMEOUT+1);
  localparam note_t LAST  = note_t'(NUM_KEYS-1);

  state_e                  state_q, state_d;
  logic [NUM_KEYS-1:0]     snap_q, snap_d;
  note_t                   idx_q, idx_d;
  logic [NW-1:0]           sh_note_q, sh_note_d;
  logic [NUM_VOICES-1:0]   sh_valid_q, sh_valid_d;
  logic [NW-1:0]           note_q, note_d;
  logic [NUM_VOICES-1:0]   valid_q, valid_d;
  logic [2:0]              num_q, num_d;
  logic                    go_q, go_d;
  logic                    ovr_q, ovr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]           ages;

  logic                    key_on;
  logic [NUM_VOICES-1:0]   rel, match, keep, pick;
  logic                    found, alloc;

  assign key_on = snap_q[idx_q];

  always_comb begin
    rel   = '0;
    match = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (sh_valid_q[v] && sh_note_q[v*NOTE_W +: NOTE_W] == idx_q) begin
        rel[v]   = !key_on;
        match[v] = key_on;
      end
    end
  end

  assign keep  = sh_valid_q & ~rel;
  assign alloc = key_on & found;

  voice_slot_pick u_pick (
    .valid_i (keep),
    .ages_i  (ages),
    .match_i (match),
    .pick_o  (pick),
    .found_o (found)
  );

`ifdef VOICE_SCHED_STEAL_EN
  logic [AW-1:0] age_q, age_d;
  assign ages = age_q;

  always_comb begin
    age_d = age_q;
    if (state_q == SCAN && alloc) begin
      for (int v = 0; v < NUM_VOICES; v++)
        if (pick[v]) age_d[v*AGE_W +: AGE_W] = '0;
    end else if (state_q == COMMIT) begin
      for (int v = 0; v < NUM_VOICES; v++)
        if (sh_valid_q[v] && age_q[v*AGE_W +: AGE_W] != '1)
          age_d[v*AGE_W +: AGE_W] = age_q[v*AGE_W +: AGE_W] + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) age_q <= '0;
    else        age_q <= age_d;
  end
`else
  assign ages = '0;
`endif

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    sh_note_d  = sh_note_q;
    sh_valid_d = sh_valid_q;
    note_d     = note_q;
    valid_d    = valid_q;
    num_d      = num_q;
    go_d       = 1'b0;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;
    if (bus.sample_tick && state_q != IDLE)
      ovr_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.sample_tick) begin
          snap_d  = bus.keys;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        sh_valid_d = keep | (alloc ? pick : '0);
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (rel[v])
            sh_note_d[v*NOTE_W +: NOTE_W] = '0;
          if (alloc && pick[v])
            sh_note_d[v*NOTE_W +: NOTE_W] = idx_q;
        end
        // Outputs load on entry to COMMIT and hold for the whole cycle
        if (idx_q == LAST) begin
          note_d  = sh_note_d;
          valid_d = sh_valid_d;
          num_d   = popcount4(sh_valid_d);
          go_d    = 1'b1;
          cnt_d   = '0;
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + note_t'(1);
        end
      end
      COMMIT: state_d = WAIT_RDY;
      WAIT_RDY: begin
        if (bus.comb_ready) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(RDY_TIMEOUT-1)) begin
          ovr_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      sh_note_q  <= '0;
      sh_valid_q <= '0;
      note_q     <= '0;
      valid_q    <= '0;
      num_q      <= '0;
      go_q       <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      sh_note_q  <= sh_note_d;
      sh_valid_q <= sh_valid_d;
      note_q     <= note_d;
      valid_q    <= valid_d;
      num_q      <= num_d;
      go_q       <= go_d;
      ovr_q      <= ovr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.voice_note  = note_q;
  assign bus.voice_valid = valid_q;
  assign bus.num_signals = num_q;
  assign bus.sample_go   = go_q;
  assign bus.overrun     = ovr_q;
  assign bus.busy        = (state_q != IDLE);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < NUM_VOICES; i++)
        for (int j = i+1; j < NUM_VOICES; j++)
          assert (!(sh_valid_q[i] && sh_valid_q[j] &&
                    sh_note_q[i*NOTE_W +: NOTE_W] ==
                    sh_note_q[j*NOTE_W +: NOTE_W]))
          else $error("voice_scheduler: duplicate note in slots %0d/%0d", i, j);
    end
  end
`endif
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler (default build).
// Inputs driven and outputs sampled on the falling edge.
module tb_voice_scheduler;
  import voice_sched_pkg::*;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  voice_scheduler_if #(.NUM_KEYS(13)) bus ();

  voice_scheduler #(
    .NUM_KEYS    (13),
    .NUM_VOICES  (4),
    .RDY_TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] vmask(input logic [3:0] v);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      m[i*4 +: 4] = {4{v[i]}};
    return m;
  endfunction

  task automatic do_reset();
    bus.keys        = '0;
    bus.sample_tick = 1'b0;
    bus.comb_ready  = 1'b0;
    n_rst           = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  // Returns negedges from the tick cycle until sample_go is seen
  task automatic tick_wait(input logic [12:0] k, input logic [12:0] kmid,
                           output int lat);
    bus.keys        = k;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    lat = 1;
    while (bus.sample_go !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 5) bus.keys = kmid;
    end
  endtask

  task automatic run_sample(input string tag, input logic [12:0] k,
                            input logic [12:0] kmid, input logic [15:0] en,
                            input logic [3:0] ev, input logic [2:0] num);
    int lat;
    tick_wait(k, kmid, lat);
    chk({tag, "_lat"}, lat, 14);
    chk({tag, "_note"}, bus.voice_note & vmask(ev), en);
    chk({tag, "_valid"}, bus.voice_valid, ev);
    chk({tag, "_num"}, bus.num_signals, num);
    chk({tag, "_busy_commit"}, bus.busy, 1);
    bus.comb_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_go_pulse"}, bus.sample_go, 0);
    chk({tag, "_rdy_in_commit"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_idle"}, bus.busy, 0);
    bus.comb_ready = 1'b0;
  endtask

  initial begin
    int gos;
    int w;
    int lat;

    do_reset();
    chk("rst_note", bus.voice_note, 0);
    chk("rst_valid", bus.voice_valid, 0);
    chk("rst_num", bus.num_signals, 0);
    chk("rst_go", bus.sample_go, 0);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_busy", bus.busy, 0);

    run_sample("single", 13'h0008, 13'h0008, 16'h0003, 4'h1, 3'd1);
    chk("single_ovr", bus.overrun, 0);

    do_reset();
    run_sample("five", 13'h0155, 13'h1FFF, 16'h6420, 4'hF, 3'd4);
    run_sample("refill", 13'h0451, 13'h0451, 16'h64A0, 4'hF, 3'd4);
    run_sample("drop", 13'h0551, 13'h0000, 16'h64A0, 4'hF, 3'd4);
    run_sample("partial", 13'h0141, 13'h0141, 16'h6800, 4'hD, 3'd3);
    chk("seq_ovr", bus.overrun, 0);

    // Second tick during SCAN
    do_reset();
    bus.comb_ready  = 1'b1;
    bus.keys        = 13'h0001;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_before", bus.overrun, 0);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    chk("ovr_tick", bus.overrun, 1);
    gos = 0;
    repeat (40) begin
      if (bus.sample_go === 1'b1) gos++;
      @(negedge clk);
    end
    chk("ovr_one_go", gos, 1);
    chk("ovr_valid", bus.voice_valid, 4'h1);
    chk("ovr_busy", bus.busy, 0);
    bus.comb_ready = 1'b0;

    // Ready never arrives
    do_reset();
    tick_wait(13'h0008, 13'h0008, lat);
    chk("tmo_lat", lat, 14);
    chk("tmo_ovr_before", bus.overrun, 0);
    w = 0;
    while (bus.busy === 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("tmo_cycles", w, 16);
    chk("tmo_ovr", bus.overrun, 1);
    chk("tmo_valid", bus.voice_valid, 4'h1);

    // Reset while SCAN is on idx 6
    bus.comb_ready  = 1'b1;
    bus.keys        = 13'h1001;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy_pre", bus.busy, 1);
    n_rst = 1'b0;
    #1;
    chk("mid_note", bus.voice_note, 0);
    chk("mid_valid", bus.voice_valid, 0);
    chk("mid_num", bus.num_signals, 0);
    chk("mid_go", bus.sample_go, 0);
    chk("mid_ovr", bus.overrun, 0);
    chk("mid_busy", bus.busy, 0);
    @(negedge clk);
    n_rst          = 1'b1;
    bus.comb_ready = 1'b0;
    @(negedge clk);
    run_sample("post_rst", 13'h0008, 13'h0008, 16'h0003, 4'h1, 3'd1);
    chk("post_rst_ovr", bus.overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
